z80_im2_ack_master: RTL and testbench

- CPU-side counterpart of the daisy-chain interrupt peripheral.
- Samples the chain's INT_n and runs a Z80 IM2 interrupt-acknowledge cycle (M1_n+IORQ_n).
- Captures the vector from the bus and presents the 16-bit IM2 table address to the host.
- On host request, replays a RETI opcode-fetch pair (ED, 4D) on M1_n/RD_n/DO so chain devices release IEO.
- Used as the bus master for soft-core integration and as chain stimulus.

---
 rtl/z80_im2_ack_master_pkg.sv | 21 ++
 rtl/z80_im2_ack_master_sync2.sv | 24 ++
 rtl/z80_im2_ack_master.sv | 159 +++++++++++++++
 tb/tb_z80_im2_ack_master.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/z80_im2_ack_master_pkg.sv
// Shared definitions for the Z80 IM2 acknowledge master and the daisy-chain peripheral side.
package z80_im2_ack_master_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACK_M1,
    ST_ACK_IORQ,
    ST_ACK_END,
    ST_RF1,
    ST_GAP1,
    ST_RF2,
    ST_GAP2
  } state_e;

  localparam logic [7:0] OP_ED = 8'hED;
  localparam logic [7:0] OP_4D = 8'h4D;
  localparam logic [7:0] OP_CB = 8'hCB;

  localparam int CNT_W = 4;

endpackage

// File: rtl/z80_im2_ack_master_sync2.sv
// Two-flop level synchroniser; resets to the inactive-high level of INT_n.
module z80_sync2 (
  input  logic CLK,
  input  logic RESET,
  input  logic i_d,
  output logic o_q
);

  logic r_s1;
  logic r_s2;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_s1 <= 1'b1;
      r_s2 <= 1'b1;
    end else begin
      r_s1 <= i_d;
      r_s2 <= r_s1;
    end
  end

  assign o_q = r_s2;

endmodule

// File: rtl/z80_im2_ack_master.sv
// Z80 IM2 bus master: runs the interrupt-acknowledge cycle and replays RETI (ED 4D) fetches.
// Define Z80_WAIT_EN to let WAIT_n stretch the final strobe clock of IORQ/opcode-fetch phases.
module z80_im2_ack_master
  import z80_im2_ack_master_pkg::*;
#(
  parameter int ACK_WAIT  = 2,
  parameter int FETCH_CYC = 2
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        INT_n,
  input  logic [7:0]  DI,
  input  logic        WAIT_n,
  output logic [7:0]  DO,
  output logic        M1_n,
  output logic        IORQ_n,
  output logic        RD_n,
  output logic        IEI_TOP,
  input  logic        IE,
  input  logic [7:0]  I_REG,
  input  logic        RETI_REQ,
  output logic        VEC_VALID,
  output logic [15:0] VEC_ADDR,
  output logic        RETI_DONE,
  output logic        BUSY
);

  localparam logic [CNT_W-1:0] ACK_LOAD   = CNT_W'(ACK_WAIT - 1);
  localparam logic [CNT_W-1:0] FETCH_LOAD = CNT_W'(FETCH_CYC - 1);

  state_e           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_reti_pend;
  logic             r_m1_n;
  logic             r_iorq_n;
  logic             r_rd_n;
  logic [7:0]       r_do;
  logic             r_vec_valid;
  logic [15:0]      r_vec_addr;
  logic             r_reti_done;
  logic             w_int_s;
  logic             w_wait_ok;
  logic             w_reti;
  logic             w_strobe_end;

  z80_sync2 u_int_sync (
    .CLK   (CLK),
    .RESET (RESET),
    .i_d   (INT_n),
    .o_q   (w_int_s)
  );

`ifdef Z80_WAIT_EN
  assign w_wait_ok = WAIT_n;
`else
  logic w_unused_wait_n;
  assign w_unused_wait_n = WAIT_n;
  assign w_wait_ok       = 1'b1;
`endif

  assign w_reti       = RETI_REQ | r_reti_pend;
  assign w_strobe_end = (r_cnt == '0) && w_wait_ok;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_reti_pend <= 1'b0;
      r_m1_n      <= 1'b1;
      r_iorq_n    <= 1'b1;
      r_rd_n      <= 1'b1;
      r_do        <= 8'h00;
      r_vec_valid <= 1'b0;
      r_vec_addr  <= 16'h0000;
      r_reti_done <= 1'b0;
    end else begin
      r_vec_valid <= 1'b0;
      r_reti_done <= 1'b0;
      if (RETI_REQ && (r_state != ST_IDLE)) r_reti_pend <= 1'b1;

      case (r_state)
        // RETI wins over a pending interrupt so the chain releases IEO first.
        ST_IDLE: begin
          if (w_reti) begin
            r_reti_pend <= 1'b0;
            r_state     <= ST_RF1;
            r_m1_n      <= 1'b0;
            r_rd_n      <= 1'b0;
            r_do        <= OP_ED;
            r_cnt       <= FETCH_LOAD;
          end else if (IE && !w_int_s) begin
            r_state <= ST_ACK_M1;
            r_m1_n  <= 1'b0;
          end
        end
        ST_ACK_M1: begin
          r_state  <= ST_ACK_IORQ;
          r_iorq_n <= 1'b0;
          r_cnt    <= ACK_LOAD;
        end
        ST_ACK_IORQ: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
          end else if (w_strobe_end) begin
            r_state     <= ST_ACK_END;
            r_m1_n      <= 1'b1;
            r_iorq_n    <= 1'b1;
            r_vec_valid <= 1'b1;
            r_vec_addr  <= {I_REG, DI[7:1], 1'b0};
          end
        end
        ST_ACK_END: r_state <= ST_IDLE;
        ST_RF1: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
          end else if (w_strobe_end) begin
            r_state <= ST_GAP1;
            r_m1_n  <= 1'b1;
            r_rd_n  <= 1'b1;
          end
        end
        // DO keeps ED through the gap so the byte is stable at the rising M1_n edge.
        ST_GAP1: begin
          r_state <= ST_RF2;
          r_m1_n  <= 1'b0;
          r_rd_n  <= 1'b0;
          r_do    <= OP_4D;
          r_cnt   <= FETCH_LOAD;
        end
        ST_RF2: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
          end else if (w_strobe_end) begin
            r_state     <= ST_GAP2;
            r_m1_n      <= 1'b1;
            r_rd_n      <= 1'b1;
            r_reti_done <= 1'b1;
          end
        end
        ST_GAP2: begin
          r_state <= ST_IDLE;
          r_do    <= 8'h00;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign DO        = r_do;
  assign M1_n      = r_m1_n;
  assign IORQ_n    = r_iorq_n;
  assign RD_n      = r_rd_n;
  assign IEI_TOP   = 1'b1;
  assign VEC_VALID = r_vec_valid;
  assign VEC_ADDR  = r_vec_addr;
  assign RETI_DONE = r_reti_done;
  assign BUSY      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_z80_im2_ack_master.sv
// Self-checking bench for z80_im2_ack_master: per-cycle bus waveform built from transaction-level expectations.
module tb_z80_im2_ack_master;

  localparam int AW = 3;
  localparam int FC = 2;

  logic        CLK;
  logic        RESET;
  logic        INT_n;
  logic [7:0]  DI;
  logic        WAIT_n;
  logic [7:0]  DO;
  logic        M1_n;
  logic        IORQ_n;
  logic        RD_n;
  logic        IEI_TOP;
  logic        IE;
  logic [7:0]  I_REG;
  logic        RETI_REQ;
  logic        VEC_VALID;
  logic [15:0] VEC_ADDR;
  logic        RETI_DONE;
  logic        BUSY;

  z80_im2_ack_master #(.ACK_WAIT(AW), .FETCH_CYC(FC)) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .INT_n     (INT_n),
    .DI        (DI),
    .WAIT_n    (WAIT_n),
    .DO        (DO),
    .M1_n      (M1_n),
    .IORQ_n    (IORQ_n),
    .RD_n      (RD_n),
    .IEI_TOP   (IEI_TOP),
    .IE        (IE),
    .I_REG     (I_REG),
    .RETI_REQ  (RETI_REQ),
    .VEC_VALID (VEC_VALID),
    .VEC_ADDR  (VEC_ADDR),
    .RETI_DONE (RETI_DONE),
    .BUSY      (BUSY)
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // scoreboard: one entry per clock {m1_n, iorq_n, rd_n, do, vec_valid, reti_done, busy, vec_addr}
  logic [29:0] exp_q[$];
  logic [15:0] m_vec;
  int          n_checks;
  int          n_errors;

  typedef struct {
    logic [7:0]  i_reg;
    logic [7:0]  di;
    logic [15:0] addr;
  } ack_vec_t;

  ack_vec_t tbl[6];

  function automatic logic [29:0] ent(input logic m1, input logic iorq, input logic rd,
                                      input logic [7:0] d, input logic vv, input logic dn,
                                      input logic bz);
    return {m1, iorq, rd, d, vv, dn, bz, m_vec};
  endfunction

  task automatic push_idle(input int n);
    repeat (n) exp_q.push_back(ent(1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0));
  endtask

  // Acknowledge: sync idle clocks, M1 alone for one clock, M1+IORQ for AW(+wait), then the vector clock.
  task automatic push_ack(input logic [15:0] addr, input int sync, input int wt);
    push_idle(sync);
    exp_q.push_back(ent(1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1));
    repeat (AW + wt) exp_q.push_back(ent(1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1));
    m_vec = addr;
    exp_q.push_back(ent(1'b1, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1));
    push_idle(1);
  endtask

  task automatic push_reti();
    repeat (FC) exp_q.push_back(ent(1'b0, 1'b1, 1'b0, 8'hED, 1'b0, 1'b0, 1'b1));
    exp_q.push_back(ent(1'b1, 1'b1, 1'b1, 8'hED, 1'b0, 1'b0, 1'b1));
    repeat (FC) exp_q.push_back(ent(1'b0, 1'b1, 1'b0, 8'h4D, 1'b0, 1'b0, 1'b1));
    exp_q.push_back(ent(1'b1, 1'b1, 1'b1, 8'h4D, 1'b0, 1'b1, 1'b1));
    push_idle(1);
  endtask

  function automatic logic [15:0] im2_addr(input logic [7:0] i, input logic [7:0] d);
    return {8'h00, i} * 16'd256 + {8'h00, d & 8'hFE};
  endfunction

  // driver: advance one clock, sample 1 time unit after the rising edge, compare against the queue head
  task automatic check_n(input int n, input string nm);
    logic [29:0] act;
    logic [29:0] exp;
    repeat (n) begin
      @(posedge CLK);
      #1;
      act = {M1_n, IORQ_n, RD_n, DO, VEC_VALID, RETI_DONE, BUSY, VEC_ADDR};
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL %s: no expectation queued, got %h", nm, act);
      end else begin
        exp = exp_q.pop_front();
        if (act !== exp) begin
          n_errors++;
          $display("FAIL %s @%0t: got m1/iorq/rd/do/vv/done/busy/addr=%h required %h",
                   nm, $time, act, exp);
        end
      end
    end
  endtask

  task automatic check_all(input string nm);
    while (exp_q.size() > 0) check_n(1, nm);
  endtask

  logic [15:0] addr;
  logic [7:0]  di1;
  logic [7:0]  di2;
  int          op;

  initial begin
    n_checks = 0;
    n_errors = 0;
    m_vec    = 16'h0000;
    RESET    = 1'b1;
    INT_n    = 1'b1;
    DI       = 8'h00;
    WAIT_n   = 1'b1;
    IE       = 1'b1;
    I_REG    = 8'h00;
    RETI_REQ = 1'b0;

    tbl[0] = '{8'h80, 8'h17, 16'h8016};
    tbl[1] = '{8'h00, 8'h00, 16'h0000};
    tbl[2] = '{8'hFF, 8'hFF, 16'hFFFE};
    tbl[3] = '{8'h12, 8'h35, 16'h1234};
    tbl[4] = '{8'hA5, 8'h5A, 16'hA55A};
    tbl[5] = '{8'h3C, 8'h01, 16'h3C00};

    // reset state
    push_idle(2);
    check_n(2, "reset");
    RESET = 1'b0;
    push_idle(2);
    check_n(2, "post_reset");
    n_checks++;
    if (IEI_TOP !== 1'b1) begin
      n_errors++;
      $display("FAIL iei_top: got %b required 1", IEI_TOP);
    end

    // table-driven acknowledges; INT_n released once M1 starts
    for (int k = 0; k < 6; k++) begin
      I_REG = tbl[k].i_reg;
      DI    = tbl[k].di;
      push_ack(tbl[k].addr, 2, 0);
      push_idle(2);
      INT_n = 1'b0;
      check_n(3, "ack_tbl");
      INT_n = 1'b1;
      I_REG = tbl[k].i_reg;
      check_all("ack_tbl");
      I_REG = ~tbl[k].i_reg;
      push_idle(1);
      check_all("vec_hold");
    end

    // RETI replay
    push_reti();
    RETI_REQ = 1'b1;
    check_n(1, "reti");
    RETI_REQ = 1'b0;
    check_all("reti");

    // RETI and interrupt in IDLE together: RETI first, then acknowledge
    I_REG = 8'h44;
    DI    = 8'h21;
    IE    = 1'b0;
    INT_n = 1'b0;
    push_idle(3);
    push_reti();
    push_ack(im2_addr(8'h44, 8'h21), 0, 0);
    check_n(3, "prio_idle");
    IE       = 1'b1;
    RETI_REQ = 1'b1;
    check_n(1, "prio_reti");
    RETI_REQ = 1'b0;
    check_n(2 * FC + 3, "prio_reti");
    INT_n = 1'b1;
    check_all("prio_ack");

    // RETI request during ACK_IORQ is serviced right after the acknowledge
    I_REG = 8'h90;
    DI    = 8'hC3;
    push_ack(im2_addr(8'h90, 8'hC3), 2, 0);
    push_reti();
    INT_n = 1'b0;
    check_n(3, "pend_ack");
    INT_n = 1'b1;
    check_n(1, "pend_ack");
    RETI_REQ = 1'b1;
    check_n(1, "pend_ack");
    RETI_REQ = 1'b0;
    check_all("pend_reti");

    // IE=0 holds off the acknowledge; IE=0 after start does not abort it
    I_REG = 8'h5E;
    DI    = 8'h77;
    IE    = 1'b0;
    INT_n = 1'b0;
    push_idle(20);
    check_all("ie_block");
    IE = 1'b1;
    push_ack(im2_addr(8'h5E, 8'h77), 0, 0);
    push_idle(3);
    check_n(1, "ie_start");
    IE    = 1'b0;
    INT_n = 1'b1;
    check_all("ie_inflight");
    IE = 1'b1;

    // WAIT_n low for 3 clocks at the end of IORQ; DI changes when WAIT_n releases
    di1   = 8'h2A;
    di2   = 8'hB5;
    I_REG = 8'h61;
    DI    = di1;
`ifdef Z80_WAIT_EN
    push_ack(im2_addr(8'h61, di2), 2, 3);
`else
    push_ack(im2_addr(8'h61, di1), 2, 0);
`endif
    push_idle(4);
    INT_n = 1'b0;
    check_n(3, "wait_ack");
    INT_n  = 1'b1;
    WAIT_n = 1'b0;
    check_n(AW + 3, "wait_ack");
    WAIT_n = 1'b1;
    DI     = di2;
    check_all("wait_ack");

    // reset in RF1: strobes high, DO=00, no RETI_DONE
    exp_q.push_back(ent(1'b0, 1'b1, 1'b0, 8'hED, 1'b0, 1'b0, 1'b1));
    RETI_REQ = 1'b1;
    check_n(1, "rst_rf1");
    RETI_REQ = 1'b0;
    RESET    = 1'b1;
    m_vec    = 16'h0000;
    push_idle(1);
    check_n(1, "rst_rf1");
    RESET = 1'b0;
    push_idle(2 * FC + 4);
    check_all("rst_rf1_after");

    // reset clears a latched RETI request
    I_REG = 8'h11;
    DI    = 8'h22;
    push_idle(2);
    exp_q.push_back(ent(1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1));
    exp_q.push_back(ent(1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1));
    INT_n = 1'b0;
    check_n(3, "rst_pend");
    INT_n    = 1'b1;
    RETI_REQ = 1'b1;
    check_n(1, "rst_pend");
    RETI_REQ = 1'b0;
    RESET    = 1'b1;
    m_vec    = 16'h0000;
    push_idle(1);
    check_n(1, "rst_pend");
    RESET = 1'b0;
    push_idle(2 * FC + 6);
    check_all("rst_pend_after");

    // randomized transactions against the transaction-level model
    for (int k = 0; k < 30; k++) begin
      op    = $urandom_range(0, 2);
      I_REG = 8'($urandom_range(0, 255));
      DI    = 8'($urandom_range(0, 255));
      case (op)
        0: begin
          addr = im2_addr(I_REG, DI);
          push_ack(addr, 2, 0);
          INT_n = 1'b0;
          check_n(3, "rnd_ack");
          INT_n = 1'b1;
          check_all("rnd_ack");
        end
        1: begin
          push_reti();
          RETI_REQ = 1'b1;
          check_n(1, "rnd_reti");
          RETI_REQ = 1'b0;
          check_all("rnd_reti");
        end
        default: begin
          push_idle($urandom_range(1, 4));
          check_all("rnd_idle");
        end
      endcase
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
